// File: rtl/lcd_bus_rx.sv
// -----------------------------------------------------------------------------
// lcd_bus_rx
//   Responder end of an ST7920-style 12864 parallel LCD bus. The asynchronous
//   bus (rs/rw/en/data) is synchronized into clk, each qualified falling edge
//   of en becomes one transfer event, and events are decoded into instruction
//   reports, basic/extended mode tracking and byte writes into a 1024-byte
//   (128x64, 1 bpp) frame buffer.
//
// Parameters
//   SYNC_STAGES  synchronizer depth on rs, rw, en and data
//   MIN_EN_HIGH  minimum synchronized en-high length (clk cycles) of a transfer
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-low reset
//   rs          register select: 0 = instruction, 1 = data
//   rw          direction: 0 = write, 1 = read (unsupported, flagged)
//   en          enable; the transfer is taken on its falling edge
//   data[7:0]   bus data
//   cmd_valid   1-cycle pulse per accepted instruction
//   cmd_byte    last accepted instruction byte
//   ext_mode    RE bit of the last function set
//   graphic_on  G bit of the last extended function set
//   disp_on     D bit of the last basic display control
//   fb_we       1-cycle frame-buffer write strobe
//   fb_addr     {x[3], y[4:0], x[2:0], hilo} of the last write
//   fb_data     byte of the last write
//   frame_done  pulse with the write to address 1023
//   proto_err   sticky protocol error flag
// -----------------------------------------------------------------------------
module lcd_bus_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_EN_HIGH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs,
    input  logic       rw,
    input  logic       en,
    input  logic [7:0] data,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       ext_mode,
    output logic       graphic_on,
    output logic       disp_on,
    output logic       fb_we,
    output logic [9:0] fb_addr,
    output logic [7:0] fb_data,
    output logic       frame_done,
    output logic       proto_err
);

    localparam int CNT_W = $clog2(MIN_EN_HIGH + 1);

    typedef enum logic [1:0] {
        A_IDLE,
        A_YSET,
        A_READY
    } phase_t;

    // Synchronizer chain; each stage carries {rs, rw, en, data} so all four
    // bus fields stay aligned to the same clk sample.
    logic [SYNC_STAGES-1:0][10:0] sync_q;
    logic [10:0]                  bus_s;
    logic                         rs_s, rw_s, en_s;
    logic [7:0]                   data_s;

    assign bus_s  = sync_q[SYNC_STAGES-1];
    assign rs_s   = bus_s[10];
    assign rw_s   = bus_s[9];
    assign en_s   = bus_s[8];
    assign data_s = bus_s[7:0];

    // One-cycle-delayed copy of the synchronized bus: when the fall is seen,
    // these hold the last sample taken while en was still high.
    logic             en_d, rs_d, rw_d;
    logic [7:0]       data_d;
    logic [CNT_W-1:0] hi_cnt;
    logic             en_fall;
    logic             long_enough;

    assign en_fall     = en_d & ~en_s;
    assign long_enough = (hi_cnt == CNT_W'(MIN_EN_HIGH));

    // Registered transfer event feeding the decoder.
    logic       ev_valid, ev_rs, ev_rw;
    logic [7:0] ev_data;

    // NOTE: synchronizer flops get an explicit reset so a reset released with
    // en=0 can never present a stale en=1 and fake a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= '0;
            en_d     <= 1'b0;
            rs_d     <= 1'b0;
            rw_d     <= 1'b0;
            data_d   <= '0;
            hi_cnt   <= '0;
            ev_valid <= 1'b0;
            ev_rs    <= 1'b0;
            ev_rw    <= 1'b0;
            ev_data  <= '0;
        end else begin
            sync_q[0] <= {rs, rw, en, data};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end

            en_d   <= en_s;
            rs_d   <= rs_s;
            rw_d   <= rw_s;
            data_d <= data_s;

            // Saturates at MIN_EN_HIGH; only "long enough or not" matters.
            if (en_s) begin
                if (hi_cnt < CNT_W'(MIN_EN_HIGH)) begin
                    hi_cnt <= hi_cnt + CNT_W'(1);
                end
            end else begin
                hi_cnt <= '0;
            end

            ev_valid <= en_fall & long_enough;
            if (en_fall) begin
                ev_rs   <= rs_d;
                ev_rw   <= rw_d;
                ev_data <= data_d;
            end
        end
    end

    // Address state: two-step vertical/horizontal address set.
    phase_t     phase;
    logic [3:0] x;
    logic [4:0] y;
    logic       hilo;
    logic [9:0] wr_addr;

    assign wr_addr = {x[3], y, x[2:0], hilo};

    // NOTE: all state below uses non-blocking assignments so every branch
    // reads the pre-edge values of ext_mode, phase, x and hilo.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_valid  <= 1'b0;
            cmd_byte   <= '0;
            ext_mode   <= 1'b0;
            graphic_on <= 1'b0;
            disp_on    <= 1'b0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            frame_done <= 1'b0;
            proto_err  <= 1'b0;
            phase      <= A_IDLE;
            x          <= '0;
            y          <= '0;
            hilo       <= 1'b0;
        end else begin
            cmd_valid  <= 1'b0;
            fb_we      <= 1'b0;
            frame_done <= 1'b0;

            if (ev_valid) begin
                if (ev_rw) begin
                    // Reads are not modelled; the transfer is only flagged.
                    proto_err <= 1'b1;
                end else if (!ev_rs) begin
                    cmd_valid <= 1'b1;
                    cmd_byte  <= ev_data;
                    if (ev_data[7:5] == 3'b001) begin
                        // Function set is recognised in both instruction sets.
                        ext_mode <= ev_data[2];
                        if (ev_data[2]) begin
                            graphic_on <= ev_data[1];
                        end
                        if (ev_data[2] != ext_mode) begin
                            phase <= A_IDLE;
                        end
                    end else if (!ext_mode) begin
                        if (ev_data[7:3] == 5'b00001) begin
                            disp_on <= ev_data[2];
                        end
                    end else if (ev_data[7]) begin
                        case (phase)
                            A_IDLE, A_READY: begin
                                y     <= ev_data[4:0];
                                phase <= A_YSET;
                            end
                            A_YSET: begin
                                x     <= ev_data[3:0];
                                hilo  <= 1'b0;
                                phase <= A_READY;
                            end
                            default: phase <= A_IDLE;
                        endcase
                    end
                end else if (ext_mode) begin
                    if (phase == A_READY) begin
                        fb_we      <= 1'b1;
                        fb_addr    <= wr_addr;
                        fb_data    <= ev_data;
                        frame_done <= &wr_addr;
                        hilo       <= ~hilo;
                        // Column advances after the low byte of each word.
                        if (hilo) begin
                            x <= x + 4'd1;
                        end
                    end else begin
                        proto_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
